// File: rtl/cpu_pkg.sv
// Shared CPU fetch/decode definitions.
// PC sequencer command encoding used by the decoder and pc_seq_unit.
package cpu_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_JMP  = 3'd2,
    PC_BR   = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_cmd_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack (LIFO).
// A push while full overwrites the oldest entry.
module pc_ras #(
  parameter int AW        = 12,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] mem [RAS_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == (PW+1)'(RAS_DEPTH));
  assign top   = mem[ptr - PW'(1)];
  assign ovf   = (push && full) || (pop && empty);

  always_ff @(posedge clock) begin
    if (push)
      mem[ptr] <= din;
  end

  // ptr names the next free slot; once full it is also the oldest entry
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full)
        cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer with optional return stack.
// Define PC_RAS_EN to build the call/return address stack.
module pc_seq_unit
  import cpu_pkg::*;
#(
  parameter int            AW        = 12,
  parameter int            STEP      = 1,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [CMD_W-1:0] pc_cmd,
  input  logic [AW-1:0]    pc_datain,
  output logic [AW-1:0]    pc_dataout,
  output logic [AW-1:0]    pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             pc_err
);

  localparam logic [AW-1:0] STEP_V = AW'(STEP);

  logic [AW-1:0] inc;

  assign inc = pc_dataout + STEP_V;

`ifdef PC_RAS_EN
  logic          push;
  logic          pop;
  logic          ovf;
  logic [AW-1:0] top;

  pc_ras #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (inc),
    .top     (top),
    .full    (ras_full),
    .empty   (ras_empty),
    .ovf     (ovf)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      pc_err <= 1'b0;
    else
      pc_err <= ovf;
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign pc_err    = 1'b0;
`endif

  always_comb begin
    pc_next = pc_dataout;
`ifdef PC_RAS_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    if (!stall) begin
      case (pc_cmd)
        PC_INC:  pc_next = inc;
        PC_JMP:  pc_next = pc_datain;
        PC_BR:   pc_next = pc_dataout + pc_datain;
        PC_CALL: begin
          pc_next = pc_datain;
`ifdef PC_RAS_EN
          push = 1'b1;
`endif
        end
        PC_RET: begin
`ifdef PC_RAS_EN
          pop     = 1'b1;
          pc_next = ras_empty ? inc : top;
`else
          pc_next = inc;
`endif
        end
        default: pc_next = pc_dataout;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      pc_dataout <= RESET_VEC;
    else
      pc_dataout <= pc_next;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit (AW=12, RESET_VEC=0x100).
// Stack checks run when PC_RAS_EN is defined.
module tb_pc_seq_unit;
  import cpu_pkg::*;

  localparam int AW = 12;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             stall;
  logic [CMD_W-1:0] pc_cmd;
  logic [AW-1:0]    pc_datain;
  logic [AW-1:0]    pc_dataout;
  logic [AW-1:0]    pc_next;
  logic             ras_empty;
  logic             ras_full;
  logic             pc_err;

  int n_cmp = 0;
  int n_bad = 0;

  pc_seq_unit #(
    .AW        (AW),
    .STEP      (1),
    .RESET_VEC (12'h100),
    .RAS_DEPTH (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .pc_cmd     (pc_cmd),
    .pc_datain  (pc_datain),
    .pc_dataout (pc_dataout),
    .pc_next    (pc_next),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .pc_err     (pc_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // drive one command, check preview, clock it, check PC and error pulse
  task automatic step(input string tag, input logic [2:0] c,
                      input logic [AW-1:0] d, input logic s,
                      input logic [AW-1:0] exp, input logic exp_err);
    pc_cmd    = c;
    pc_datain = d;
    stall     = s;
    #1;
    chk({tag, ".next"}, 32'(pc_next), 32'(exp));
    @(posedge clock);
    #1;
    chk({tag, ".pc"}, 32'(pc_dataout), 32'(exp));
    chk({tag, ".err"}, 32'(pc_err), 32'(exp_err));
  endtask

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    pc_cmd    = PC_HOLD;
    pc_datain = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.pc", 32'(pc_dataout), 32'h100);
    chk("rst.empty", 32'(ras_empty), 32'h1);
    chk("rst.full", 32'(ras_full), 32'h0);
    chk("rst.err", 32'(pc_err), 32'h0);
    reset_n = 1'b1;

    step("jmp55", PC_JMP, 12'h055, 1'b0, 12'h055, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.pc", 32'(pc_dataout), 32'h100);
    @(posedge clock);
    #1 reset_n = 1'b1;
    step("inc1", PC_INC, 12'h000, 1'b0, 12'h101, 1'b0);
    step("inc2", PC_INC, 12'h000, 1'b0, 12'h102, 1'b0);
    step("inc3", PC_INC, 12'h000, 1'b0, 12'h103, 1'b0);
    step("rsv6", 3'd6, 12'h777, 1'b0, 12'h103, 1'b0);
    step("rsv7", 3'd7, 12'h777, 1'b0, 12'h103, 1'b0);

    step("wjmp", PC_JMP, 12'hFFE, 1'b0, 12'hFFE, 1'b0);
    step("winc1", PC_INC, 12'h000, 1'b0, 12'hFFF, 1'b0);
    step("winc2", PC_INC, 12'h000, 1'b0, 12'h000, 1'b0);
    step("brm1", PC_BR, 12'hFFF, 1'b0, 12'hFFF, 1'b0);
    step("brp5", PC_BR, 12'h005, 1'b0, 12'h004, 1'b0);

    step("sjmp", PC_JMP, 12'h020, 1'b0, 12'h020, 1'b0);
    step("stl1", PC_JMP, 12'h300, 1'b1, 12'h020, 1'b0);
    step("stl2", PC_JMP, 12'h300, 1'b1, 12'h020, 1'b0);
    step("unstl", PC_JMP, 12'h300, 1'b0, 12'h300, 1'b0);

`ifdef PC_RAS_EN
    step("njmp", PC_JMP, 12'h010, 1'b0, 12'h010, 1'b0);
    step("call1", PC_CALL, 12'h200, 1'b0, 12'h200, 1'b0);
    chk("call1.empty", 32'(ras_empty), 32'h0);
    step("call2", PC_CALL, 12'h400, 1'b0, 12'h400, 1'b0);
    step("ret1", PC_RET, 12'h000, 1'b0, 12'h201, 1'b0);
    step("ret2", PC_RET, 12'h000, 1'b0, 12'h011, 1'b0);
    chk("nest.empty", 32'(ras_empty), 32'h1);
    step("scall", PC_CALL, 12'h222, 1'b1, 12'h011, 1'b0);
    chk("scall.empty", 32'(ras_empty), 32'h1);

    step("ojmp", PC_JMP, 12'h050, 1'b0, 12'h050, 1'b0);
    step("oc1", PC_CALL, 12'h060, 1'b0, 12'h060, 1'b0);
    step("oc2", PC_CALL, 12'h070, 1'b0, 12'h070, 1'b0);
    step("oc3", PC_CALL, 12'h080, 1'b0, 12'h080, 1'b0);
    step("oc4", PC_CALL, 12'h090, 1'b0, 12'h090, 1'b0);
    chk("oc4.full", 32'(ras_full), 32'h1);
    step("oc5", PC_CALL, 12'h0A0, 1'b0, 12'h0A0, 1'b1);
    chk("oc5.full", 32'(ras_full), 32'h1);
    step("ohold", PC_HOLD, 12'h000, 1'b0, 12'h0A0, 1'b0);
    step("or1", PC_RET, 12'h000, 1'b0, 12'h091, 1'b0);
    chk("or1.full", 32'(ras_full), 32'h0);
    step("or2", PC_RET, 12'h000, 1'b0, 12'h081, 1'b0);
    step("or3", PC_RET, 12'h000, 1'b0, 12'h071, 1'b0);
    step("or4", PC_RET, 12'h000, 1'b0, 12'h061, 1'b0);
    chk("or4.empty", 32'(ras_empty), 32'h1);
    step("or5", PC_RET, 12'h000, 1'b0, 12'h062, 1'b1);
    chk("or5.empty", 32'(ras_empty), 32'h1);
    step("uhold", PC_HOLD, 12'h000, 1'b0, 12'h062, 1'b0);
`else
    step("ncall", PC_CALL, 12'h200, 1'b0, 12'h200, 1'b0);
    chk("ncall.empty", 32'(ras_empty), 32'h1);
    chk("ncall.full", 32'(ras_full), 32'h0);
    step("nret", PC_RET, 12'h000, 1'b0, 12'h201, 1'b0);
    chk("nret.empty", 32'(ras_empty), 32'h1);
    step("nret2", PC_RET, 12'h000, 1'b0, 12'h202, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
